// File: rtl/logic_gate_pkg.sv
// Shared definitions for logic_gate_sweep: gate op encodings, FSM state type
// and the op legality check.
package logic_gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_XNOR;
  endfunction

endpackage

// File: rtl/logic_gate_sweep_gate_eval.sv
// gate_eval: combinational N_IN-input gate selected by op; illegal ops give 0.
module gate_eval
  import logic_gate_pkg::*;
#(
  parameter int unsigned N_IN = 2
) (
  input  logic [N_IN-1:0] in,
  input  logic [2:0]      op,
  output logic            out
);

  always_comb begin
    out = 1'b0;
    case (op)
      OP_AND:  out = &in;
      OP_OR:   out = |in;
      OP_NAND: out = ~&in;
      OP_NOR:  out = ~|in;
      OP_XOR:  out = ^in;
      OP_XNOR: out = ~^in;
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_gate_sweep.sv
// logic_gate_sweep: walks every input combination of an N_IN-input gate and
// captures the truth table. Optional LOGIC_GATE_SWEEP_CMP_EN adds exp/mismatch.
module logic_gate_sweep
  import logic_gate_pkg::*;
#(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned DEPTH = 2 ** N_IN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             hold,
`ifdef LOGIC_GATE_SWEEP_CMP_EN
  input  logic [DEPTH-1:0] exp,
  output logic             mismatch,
`endif
  output logic [N_IN-1:0]  vec,
  output logic             y,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [DEPTH-1:0] tt,
  output logic [N_IN:0]    ones
);

  localparam int unsigned OW = N_IN + 1;
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(DEPTH - 1);

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [N_IN-1:0] idx;
  logic            f;
  logic            last;

  gate_eval #(.N_IN(N_IN)) u_eval (
    .in (idx),
    .op (op_q),
    .out(f)
  );

  assign last = (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == ST_SWEEP);
    case (state)
      ST_IDLE:  if (start) state_nxt = op_legal(op) ? ST_SWEEP : ST_DONE;
      ST_SWEEP: if (!hold && last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // done is registered off the DONE state so it trails the last valid by a cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec      <= '0;
      y        <= 1'b0;
      valid    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tt       <= '0;
      ones     <= '0;
      idx      <= '0;
      op_q     <= '0;
`ifdef LOGIC_GATE_SWEEP_CMP_EN
      mismatch <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      done  <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= op;
            err      <= ~op_legal(op);
            tt       <= '0;
            ones     <= '0;
            idx      <= '0;
`ifdef LOGIC_GATE_SWEEP_CMP_EN
            mismatch <= 1'b0;
`endif
          end
        end
        ST_SWEEP: begin
          if (!hold) begin
            vec     <= idx;
            y       <= f;
            valid   <= 1'b1;
            tt[idx] <= f;
            ones    <= ones + OW'(f);
            if (!last) idx <= idx + N_IN'(1);
          end
        end
        ST_DONE: begin
`ifdef LOGIC_GATE_SWEEP_CMP_EN
          mismatch <= (tt != exp);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gate_sweep.sv
// Bench for logic_gate_sweep: N_IN=2 and N_IN=3 instances on shared stimulus,
// checked against a truth-table model derived from the gate definitions.
module tb_logic_gate_sweep;

  logic       clk = 1'b0;
  logic       rst, start, hold;
  logic [2:0] op;

  logic [1:0] vec2;  logic y2, valid2, busy2, done2, err2;
  logic [3:0] tt2;   logic [2:0] ones2;
  logic [2:0] vec3;  logic y3, valid3, busy3, done3, err3;
  logic [7:0] tt3;   logic [3:0] ones3;
`ifdef LOGIC_GATE_SWEEP_CMP_EN
  logic [3:0] exp2;  logic [7:0] exp3;  logic mm2, mm3;
`endif

  logic [7:0] o_vec [2];
  logic [7:0] o_tt  [2];
  logic [7:0] o_ones[2];
  logic       o_y[2], o_valid[2], o_busy[2], o_done[2], o_err[2];

  int checks   = 0;
  int failures = 0;

  logic_gate_sweep #(.N_IN(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .hold(hold),
`ifdef LOGIC_GATE_SWEEP_CMP_EN
    .exp(exp2), .mismatch(mm2),
`endif
    .vec(vec2), .y(y2), .valid(valid2), .busy(busy2), .done(done2),
    .err(err2), .tt(tt2), .ones(ones2)
  );

  logic_gate_sweep #(.N_IN(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .op(op), .hold(hold),
`ifdef LOGIC_GATE_SWEEP_CMP_EN
    .exp(exp3), .mismatch(mm3),
`endif
    .vec(vec3), .y(y3), .valid(valid3), .busy(busy3), .done(done3),
    .err(err3), .tt(tt3), .ones(ones3)
  );

  always #5 clk = ~clk;

  always_comb begin
    o_vec[0] = 8'(vec2);  o_vec[1] = 8'(vec3);
    o_tt[0]  = 8'(tt2);   o_tt[1]  = tt3;
    o_ones[0] = 8'(ones2); o_ones[1] = 8'(ones3);
    o_y[0] = y2;         o_y[1] = y3;
    o_valid[0] = valid2; o_valid[1] = valid3;
    o_busy[0] = busy2;   o_busy[1] = busy3;
    o_done[0] = done2;   o_done[1] = done3;
    o_err[0] = err2;     o_err[1] = err3;
  end

  // Gate output for input combination k of an n-input gate.
  function automatic logic ref_f(input logic [2:0] o, input int k, input int n);
    int full;
    int pc;
    full = (1 << n) - 1;
    pc   = $countones(k);
    case (o)
      3'd0: return k == full;
      3'd1: return k != 0;
      3'd2: return k != full;
      3'd3: return k == 0;
      3'd4: return pc[0];
      3'd5: return !pc[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] ref_tt(input logic [2:0] o, input int n);
    logic [7:0] t;
    t = '0;
    for (int k = 0; k < (1 << n); k++) t[k] = ref_f(o, k, n);
    return t;
  endfunction

  function automatic int ref_ones(input logic [2:0] o, input int n);
    int c;
    c = 0;
    for (int k = 0; k < (1 << n); k++) c += int'(ref_f(o, k, n));
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hold = 1'b0; op = 3'd0;
    #3;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_vec[d] !== 8'd0 || o_y[d] !== 1'b0 || o_valid[d] !== 1'b0 || o_busy[d] !== 1'b0 ||
          o_done[d] !== 1'b0 || o_err[d] !== 1'b0 || o_tt[d] !== 8'd0 || o_ones[d] !== 8'd0) begin
        failures++;
        $display("FAIL reset dut%0d vec=%0d y=%b valid=%b busy=%b done=%b err=%b tt=%h ones=%0d expected all 0",
                 d, o_vec[d], o_y[d], o_valid[d], o_busy[d], o_done[d], o_err[d], o_tt[d], o_ones[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One sweep on both instances; hold_mask bit c drives hold before edge c+1.
  task automatic run_sweep(input logic [2:0] o, input logic [31:0] hold_mask, input bit rand_start);
    int k[2];
    int ph[2];
    int nvalid[2];
    int cyc;
    logic h;
    logic [7:0] e;
    start = 1'b1;
    op    = o;
    hold  = 1'($urandom_range(0, 1));
`ifdef LOGIC_GATE_SWEEP_CMP_EN
    e = ref_tt(o, 2);
    exp2 = ($urandom_range(0, 1) == 1) ? e[3:0] : 4'($urandom);
    e = ref_tt(o, 3);
    exp3 = ($urandom_range(0, 1) == 1) ? e : 8'($urandom);
`else
    e = '0;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_busy[d] !== 1'b1 || o_valid[d] !== 1'b0 || o_tt[d] !== 8'd0 ||
          o_ones[d] !== 8'd0 || o_err[d] !== 1'b0) begin
        failures++;
        $display("FAIL sweep_accept dut%0d op=%0d busy=%b valid=%b tt=%h ones=%0d err=%b expected busy=1 valid=0 tt=0 ones=0 err=0",
                 d, o, o_busy[d], o_valid[d], o_tt[d], o_ones[d], o_err[d]);
      end
      k[d] = 0; ph[d] = 0; nvalid[d] = 0;
    end
    cyc = 0;
    while ((ph[0] != 2 || ph[1] != 2) && cyc < 64) begin
      h     = (cyc < 32) ? hold_mask[cyc] : 1'b0;
      hold  = h;
      op    = 3'($urandom);
      start = rand_start && ph[0] == 0 && ph[1] == 0 && $urandom_range(0, 3) == 0;
      @(posedge clk); #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        int dep;
        int n;
        n   = d + 2;
        dep = 1 << n;
        if (ph[d] == 1) begin
          checks++;
          if (o_done[d] !== 1'b1 || o_valid[d] !== 1'b0 || o_busy[d] !== 1'b0 ||
              o_tt[d] !== ref_tt(o, n) || o_ones[d] !== 8'(ref_ones(o, n)) ||
              nvalid[d] != dep || o_err[d] !== 1'b0) begin
            failures++;
            $display("FAIL sweep_done dut%0d op=%0d done=%b valid=%b busy=%b tt=%h ones=%0d nvalid=%0d err=%b expected done=1 tt=%h ones=%0d nvalid=%0d",
                     d, o, o_done[d], o_valid[d], o_busy[d], o_tt[d], o_ones[d], nvalid[d], o_err[d],
                     ref_tt(o, n), ref_ones(o, n), dep);
          end
`ifdef LOGIC_GATE_SWEEP_CMP_EN
          checks++;
          if (d == 0 && mm2 !== (exp2 != tt2)) begin
            failures++;
            $display("FAIL mismatch dut2 got=%b expected=%b", mm2, exp2 != ref_tt(o, 2));
          end else if (d == 1 && mm3 !== (exp3 != ref_tt(o, 3))) begin
            failures++;
            $display("FAIL mismatch dut3 got=%b expected=%b", mm3, exp3 != ref_tt(o, 3));
          end
`endif
          ph[d] = 2;
        end else if (ph[d] == 2) begin
          checks++;
          if (o_done[d] !== 1'b0 || o_busy[d] !== 1'b0 || o_valid[d] !== 1'b0 ||
              o_tt[d] !== ref_tt(o, n)) begin
            failures++;
            $display("FAIL idle_stable dut%0d done=%b busy=%b valid=%b tt=%h expected 0 0 0 tt=%h",
                     d, o_done[d], o_busy[d], o_valid[d], o_tt[d], ref_tt(o, n));
          end
        end else if (h) begin
          checks++;
          if (o_valid[d] !== 1'b0 || o_busy[d] !== 1'b1 || (k[d] > 0 && o_vec[d] !== 8'(k[d] - 1))) begin
            failures++;
            $display("FAIL hold dut%0d valid=%b busy=%b vec=%0d expected valid=0 busy=1 vec=%0d",
                     d, o_valid[d], o_busy[d], o_vec[d], k[d] - 1);
          end
        end else begin
          checks++;
          if (o_valid[d] !== 1'b1 || o_vec[d] !== 8'(k[d]) || o_y[d] !== ref_f(o, k[d], n) ||
              o_busy[d] !== (k[d] + 1 < dep) || o_done[d] !== 1'b0) begin
            failures++;
            $display("FAIL step dut%0d op=%0d valid=%b vec=%0d y=%b busy=%b done=%b expected valid=1 vec=%0d y=%b busy=%b done=0",
                     d, o, o_valid[d], o_vec[d], o_y[d], o_busy[d], o_done[d],
                     k[d], ref_f(o, k[d], n), k[d] + 1 < dep);
          end
          nvalid[d]++;
          k[d]++;
          if (k[d] == dep) ph[d] = 1;
        end
      end
    end
    checks++;
    if (ph[0] != 2 || ph[1] != 2) begin
      failures++;
      $display("FAIL sweep_timeout op=%0d ph2=%0d ph3=%0d expected 2 2", o, ph[0], ph[1]);
    end
    hold  = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_or();
    run_sweep(3'd1, 32'h0, 1'b0);
    checks++;
    if (tt2 !== 4'b1110 || ones2 !== 3'd3) begin
      failures++;
      $display("FAIL or_table tt=%b ones=%0d expected tt=1110 ones=3", tt2, ones2);
    end
  endtask

  task automatic test_xor();
    run_sweep(3'd4, 32'h0, 1'b0);
    checks++;
    if (tt3 !== 8'b10010110 || ones3 !== 4'd4) begin
      failures++;
      $display("FAIL xor_table tt=%b ones=%0d expected tt=10010110 ones=4", tt3, ones3);
    end
  endtask

  task automatic test_hold_nor();
    run_sweep(3'd3, 32'h0000_000C, 1'b0);
    checks++;
    if (tt2 !== 4'b0001) begin
      failures++;
      $display("FAIL nor_hold_table tt=%b expected 0001", tt2);
    end
  endtask

  task automatic test_all_ops();
    for (int o = 0; o < 6; o++)
      for (int r = 0; r < 2; r++)
        run_sweep(3'(o), $urandom & $urandom, 1'b1);
  endtask

  task automatic test_illegal(input logic [2:0] o);
    start = 1'b1;
    op    = o;
    hold  = 1'($urandom_range(0, 1));
`ifdef LOGIC_GATE_SWEEP_CMP_EN
    exp2 = 4'($urandom); exp3 = 8'($urandom);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_busy[d] !== 1'b0 || o_valid[d] !== 1'b0 || o_err[d] !== 1'b1 ||
          o_tt[d] !== 8'd0 || o_ones[d] !== 8'd0 || o_done[d] !== 1'b0) begin
        failures++;
        $display("FAIL illegal_accept dut%0d op=%0d busy=%b valid=%b err=%b tt=%h ones=%0d done=%b expected 0 0 1 0 0 0",
                 d, o, o_busy[d], o_valid[d], o_err[d], o_tt[d], o_ones[d], o_done[d]);
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_done[d] !== 1'b1 || o_valid[d] !== 1'b0 || o_err[d] !== 1'b1) begin
        failures++;
        $display("FAIL illegal_done dut%0d done=%b valid=%b err=%b expected 1 0 1",
                 d, o_done[d], o_valid[d], o_err[d]);
      end
    end
`ifdef LOGIC_GATE_SWEEP_CMP_EN
    checks++;
    if (mm2 !== (exp2 != 4'd0) || mm3 !== (exp3 != 8'd0)) begin
      failures++;
      $display("FAIL illegal_mismatch got=%b%b expected=%b%b", mm2, mm3, exp2 != 4'd0, exp3 != 8'd0);
    end
`endif
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_done[d] !== 1'b0 || o_err[d] !== 1'b1 || o_valid[d] !== 1'b0 || o_tt[d] !== 8'd0) begin
        failures++;
        $display("FAIL illegal_idle dut%0d done=%b err=%b valid=%b tt=%h expected 0 1 0 0",
                 d, o_done[d], o_err[d], o_valid[d], o_tt[d]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    start = 1'b1;
    op    = 3'd0;
    hold  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!(o_valid[0] === 1'b1 && o_vec[0] == 8'd2) && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (w >= 10) begin
      failures++;
      $display("FAIL reset_mid_wait vec=%0d valid=%b expected vec=2 valid=1", o_vec[0], o_valid[0]);
    end
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_vec[d] !== 8'd0 || o_y[d] !== 1'b0 || o_valid[d] !== 1'b0 || o_busy[d] !== 1'b0 ||
          o_done[d] !== 1'b0 || o_err[d] !== 1'b0 || o_tt[d] !== 8'd0 || o_ones[d] !== 8'd0) begin
        failures++;
        $display("FAIL reset_mid dut%0d vec=%0d y=%b valid=%b busy=%b done=%b err=%b tt=%h ones=%0d expected all 0",
                 d, o_vec[d], o_y[d], o_valid[d], o_busy[d], o_done[d], o_err[d], o_tt[d], o_ones[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done2 !== 1'b0 || done3 !== 1'b0 || busy2 !== 1'b0 || busy3 !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_done done=%b%b busy=%b%b expected 00 00", done2, done3, busy2, busy3);
      end
    end
    run_sweep(3'd0, 32'h0, 1'b0);
    checks++;
    if (tt2 !== 4'b1000) begin
      failures++;
      $display("FAIL and_after_reset tt=%b expected 1000", tt2);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; op = 3'd0;
`ifdef LOGIC_GATE_SWEEP_CMP_EN
    exp2 = '0; exp3 = '0;
`endif
    test_reset();
    test_or();
    test_xor();
    test_hold_nor();
    test_illegal(3'd7);
    test_all_ops();
    test_illegal(3'd6);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
